// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV64 subset controller.
// Holds the state enum, field constants and the per-state control decode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_EXEC_R,
    ST_ALU_WB,
    ST_BEQ,
    ST_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       beq;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_sel;
    logic       illegal;
  } ctrl_t;

  // fetch/beq flag the states whose write enables follow same-cycle inputs
  function automatic ctrl_t ctrl_for(
    state_t     s,
    logic       sd,
    logic [1:0] alu_r
  );
    ctrl_t c;
    c = '0;
    unique case (s)
      ST_FETCH: begin
        c.mem_req     = 1'b1;
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.result_src  = RES_ALU;
        c.fetch       = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_sel   = IMM_B;
      end
      ST_MEM_ADR: begin
        c.alu_src_a = SRCA_REGA;
        c.alu_src_b = SRCB_IMM;
        c.imm_sel   = sd ? IMM_S : IMM_I;
      end
      ST_MEM_RD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_MDR;
      end
      ST_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a   = SRCA_REGA;
        c.alu_src_b   = SRCB_REGB;
        c.alu_control = alu_r;
      end
      ST_ALU_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      ST_BEQ: begin
        c.alu_src_a   = SRCA_REGA;
        c.alu_src_b   = SRCB_REGB;
        c.alu_control = ALU_SUB;
        c.result_src  = RES_ALUOUT;
        c.beq         = 1'b1;
      end
      ST_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request port shared between the controller and the memory.
// The controller holds req/write/adr stable until mem_ready.
interface multicycle_controller_if;

  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );

endinterface

// File: rtl/multicycle_controller_alu_funct_decoder.sv
// R-type {funct7,funct3} to ALU operation, with a legality flag.
// Only add/sub/and/or are legal.
module alu_funct_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [1:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    unique case (1'b1)
      (funct7 == F7_BASE && funct3 == F3_ADD): begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
      end
      (funct7 == F7_ALT && funct3 == F3_ADD): begin
        alu_control = ALU_SUB;
        legal       = 1'b1;
      end
      (funct7 == F7_BASE && funct3 == F3_AND): begin
        alu_control = ALU_AND;
        legal       = 1'b1;
      end
      (funct7 == F7_BASE && funct3 == F3_OR): begin
        alu_control = ALU_OR;
        legal       = 1'b1;
      end
      default: begin
        alu_control = ALU_ADD;
        legal       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for a shared-memory multicycle RV64 datapath.
// Supports ld, sd, add, sub, and, or, beq; counts retired instructions.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 zero,
  multicycle_controller_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_control,
  output logic [1:0]           imm_sel,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  state_t     state;
  state_t     state_n;
  ctrl_t      ctrl;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [1:0] alu_r;
  logic       r_legal;
  logic       is_ld;
  logic       is_sd;
  logic       is_r;
  logic       is_beq;
  logic       retire;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign unused_bits = ^{instr[24:15], instr[11:7]};

  alu_funct_decoder u_funct (
    .funct7      (f7),
    .funct3      (f3),
    .alu_control (alu_r),
    .legal       (r_legal)
  );

  assign is_ld  = (opcode == OP_LD)  && (f3 == F3_D);
  assign is_sd  = (opcode == OP_SD)  && (f3 == F3_D);
  assign is_r   = (opcode == OP_R)   && r_legal;
  assign is_beq = (opcode == OP_BEQ) && (f3 == F3_BEQ);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    state_n = ST_FETCH;
      ST_FETCH:   if (mem.mem_ready) state_n = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          is_ld:   state_n = ST_MEM_ADR;
          is_sd:   state_n = ST_MEM_ADR;
          is_r:    state_n = ST_EXEC_R;
          is_beq:  state_n = ST_BEQ;
          default: state_n = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADR: state_n = is_sd ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:  if (mem.mem_ready) state_n = ST_MEM_WB;
      ST_MEM_WB:  state_n = ST_FETCH;
      ST_MEM_WR:  if (mem.mem_ready) state_n = ST_FETCH;
      ST_EXEC_R:  state_n = ST_ALU_WB;
      ST_ALU_WB:  state_n = ST_FETCH;
      ST_BEQ:     state_n = ST_FETCH;
      ST_ILLEGAL: state_n = ST_ILLEGAL;
      default:    state_n = ST_IDLE;
    endcase
  end

  assign retire = (state == ST_MEM_WB)
               || (state == ST_MEM_WR && mem.mem_ready)
               || (state == ST_ALU_WB)
               || (state == ST_BEQ);

  // outputs are registered from the next state so they switch with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      ctrl  <= ctrl_for(state_n, is_sd, alu_r);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem.mem_req   = ctrl.mem_req;
  assign mem.mem_write = ctrl.mem_write;
  assign mem.adr_src   = ctrl.adr_src;
  assign ir_write      = ctrl.fetch & mem.mem_ready;
  assign pc_write      = (ctrl.fetch & mem.mem_ready)
                       | (ctrl.beq & zero);
  assign reg_write     = ctrl.reg_write;
  assign result_src    = ctrl.result_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_control   = ctrl.alu_control;
  assign imm_sel       = ctrl.imm_sel;
  assign illegal       = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a per-instruction
// cycle-trace model and a per-cycle output compare.
module tb_multicycle_controller;

  typedef struct packed {
    logic       req;
    logic       wr;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu;
    logic [1:0] imm;
    logic       ill;
    logic [3:0] ret;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_control;
  logic [1:0]  imm_sel;
  logic        illegal;
  logic [3:0]  retired;

  multicycle_controller_if mif();

  multicycle_controller #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .zero        (zero),
    .mem         (mif),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_sel     (imm_sel),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ncyc = 0;
  exp_t        expq[$];
  logic [3:0]  model_ret = 4'd0;
  int          model_rw = 0;
  logic [31:0] cur_instr = 32'h0;
  exp_t        got_v;
  exp_t        exp_v;

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_v = expq.pop_front();
      got_v = '{mif.mem_req, mif.mem_write, mif.adr_src,
                ir_write, pc_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, imm_sel,
                illegal, retired};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h want=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.ret = model_ret;
    return e;
  endfunction

  function automatic int alu_of(input logic [31:0] ins);
    if (ins[14:12] == 3'b000) return (ins[31:25] == 7'b0) ? 0 : 1;
    return (ins[14:12] == 3'b111) ? 2 : 3;
  endfunction

  task automatic cyc(input exp_t e, input logic rdy,
                     input logic z, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    mif.mem_ready = rdy;
    zero = z;
    instr = cur_instr;
    expq.push_back(e);
    ncyc++;
  endtask

  // Builds the expected trace of one instruction from the ISA rules
  task automatic exec(input logic [31:0] ins, input int fw, input int mw,
                      input logic z, input logic abort,
                      output int n, output logic ill);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ld, sd, rr, bq;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ld = (op == 7'h03) && (f3 == 3'd3);
    sd = (op == 7'h23) && (f3 == 3'd3);
    rr = (op == 7'h33) && (((f7 == 7'h00) && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6))
                        || ((f7 == 7'h20) && (f3 == 3'd0)));
    bq = (op == 7'h63) && (f3 == 3'd0);
    ill = !(ld || sd || rr || bq);
    n = 0;
    e = blank();
    e.req = 1; e.a = 2'd0; e.b = 2'd2; e.alu = 2'd0; e.rs = 2'd2;
    for (int i = 0; i < fw; i++) begin cyc(e, 0, z, 0); n++; end
    e.irw = 1; e.pcw = 1;
    cyc(e, 1, z, 0); n++;
    cur_instr = ins;
    e = blank();
    e.a = 2'd1; e.b = 2'd1; e.imm = 2'd2;
    cyc(e, 1, z, 0); n++;
    if (ill) return;
    if (ld || sd) begin
      e = blank();
      e.a = 2'd2; e.b = 2'd1; e.imm = sd ? 2'd1 : 2'd0;
      cyc(e, 1, z, 0); n++;
      e = blank();
      e.req = 1; e.adr = 1; e.wr = sd;
      for (int i = 0; i < mw; i++) begin
        if (abort) begin
          cyc(e, 0, z, 1); n++;
          model_ret = 4'd0;
          return;
        end
        cyc(e, 0, z, 0); n++;
      end
      cyc(e, 1, z, 0); n++;
      if (ld) begin
        e = blank();
        e.rw = 1; e.rs = 2'd1;
        model_rw++;
        cyc(e, 1, z, 0); n++;
      end
    end else if (rr) begin
      e = blank();
      e.a = 2'd2; e.b = 2'd0; e.alu = 2'(alu_of(ins));
      cyc(e, 1, z, 0); n++;
      e = blank();
      e.rw = 1; e.rs = 2'd0;
      model_rw++;
      cyc(e, 1, z, 0); n++;
    end else begin
      e = blank();
      e.a = 2'd2; e.b = 2'd0; e.alu = 2'd1; e.rs = 2'd0; e.pcw = z;
      cyc(e, 1, z, 0); n++;
    end
    model_ret = model_ret + 4'd1;
  endtask

  logic [31:0] rtab [4] = '{32'h00A30533, 32'h40A30533,
                            32'h00A37533, 32'h00A36533};

  initial begin
    int   n;
    logic il;
    exp_t e;
    rst = 1'b1;
    instr = 32'h0;
    zero = 1'b0;
    mif.mem_ready = 1'b0;
    cyc(blank(), 0, 0, 1);
    cyc(blank(), 1, 0, 0);

    model_rw = 0;
    exec(32'h36A33503, 3, 3, 0, 0, n, il);
    chk("ld_cycles", n, 11);
    chk("ld_reg_writes", model_rw, 1);

    model_rw = 0;
    exec(32'h36A33523, 0, 0, 0, 0, n, il);
    chk("sd_cycles", n, 4);
    chk("sd_reg_writes", model_rw, 0);
    chk("retired_after_sd", int'(model_ret), 2);

    for (int i = 0; i < 4; i++) begin
      chk("r_alu_table", alu_of(rtab[i]), i);
      exec(rtab[i], 0, 0, 0, 0, n, il);
      chk("r_cycles", n, 4);
    end

    exec(32'h14A30563, 0, 0, 1, 0, n, il);
    chk("beq_taken_cycles", n, 3);
    exec(32'h14A30563, 0, 0, 0, 0, n, il);
    chk("beq_not_taken_cycles", n, 3);
    chk("retired_model_8", int'(model_ret), 8);

    for (int i = 0; i < 8; i++)
      exec(32'h14A30563, 0, 0, 1'(i & 1), 0, n, il);
    chk("retired_wrap_model", int'(model_ret), 0);

    exec(32'h36A33503, 0, 2, 0, 1, n, il);
    chk("abort_cycles", n, 4);
    cyc(blank(), 1, 0, 0);
    #2;
    chk("reset_retired", int'(retired), 0);
    chk("reset_mem_req", int'(mif.mem_req), 0);

    exec(32'h02A30533, 0, 0, 0, 0, n, il);
    chk("illegal_class", int'(il), 1);
    e = blank();
    e.ill = 1;
    for (int i = 0; i < 20; i++) cyc(e, 1'(i & 1), 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
